// File: rtl/pkt_pkg.sv
`default_nettype none
// pkt_pkg -- shared types and constants for the packet serializer, rev 1.0.
package pkt_pkg;

  localparam int PKT_NUM_WORDS = 16;
  localparam int PKT_DATA_W    = 8;

  typedef struct packed {
    logic [7:0]                               addr;
    logic [PKT_NUM_WORDS-1:0][PKT_DATA_W-1:0] data;
    logic [3:0]                               cntrl;
  } pkt_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_CNTRL = 3'd2,
    S_DATA  = 3'd3
`ifdef PKT_SERIALIZER_CSUM_EN
    ,
    S_CSUM  = 3'd4
`endif
  } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/pkt_csum_acc.sv
`default_nettype none
// pkt_csum_acc -- modulo-256 byte accumulator; sum already includes din, rev 1.0.
module pkt_csum_acc
  import pkt_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  acc_en,
  input  logic [PKT_DATA_W-1:0] din,
  output logic [PKT_DATA_W-1:0] sum
);

  logic [PKT_DATA_W-1:0] acc_q;

  assign sum = acc_q + din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (acc_en) begin
      acc_q <= sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pkt_serializer.sv
`default_nettype none
// pkt_serializer -- packet record to byte stream (addr, cntrl, data, [csum]), rev 1.0.
// Trailing checksum byte is built in when PKT_SERIALIZER_CSUM_EN is defined.
module pkt_serializer
  import pkt_pkg::*;
#(
  parameter int DATA_W    = PKT_DATA_W,
  parameter int NUM_WORDS = PKT_NUM_WORDS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  in_addr,
  input  logic [NUM_WORDS*DATA_W-1:0] in_data,
  input  logic [3:0]                  in_cntrl,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_byte,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic                        busy
);

  localparam logic [7:0] LAST = 8'(NUM_WORDS - 1);
`ifdef PKT_SERIALIZER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  ser_state_t                  state;
  logic [7:0]                  addr_q;
  logic [3:0]                  cntrl_q;
  logic [NUM_WORDS*DATA_W-1:0] data_q;
  logic [7:0]                  idx;
  logic [7:0]                  idx_nxt;

  assign idx_nxt  = idx + 8'd1;
  assign in_ready = (state == S_IDLE) && !rst;
  assign busy     = (state != S_IDLE);

`ifdef PKT_SERIALIZER_CSUM_EN
  logic [DATA_W-1:0] csum_sum;

  // Accumulates every byte as it is handed downstream; csum_sum includes the byte on the bus.
  pkt_csum_acc u_csum (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state == S_IDLE) && in_valid),
    .acc_en (out_valid && out_ready && (state != S_CSUM)),
    .din    (out_byte),
    .sum    (csum_sum)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      cntrl_q   <= '0;
      data_q    <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_byte  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            addr_q    <= in_addr;
            cntrl_q   <= in_cntrl;
            data_q    <= in_data;
            idx       <= '0;
            state     <= S_ADDR;
            out_valid <= 1'b1;
            out_byte  <= in_addr;
            out_sop   <= 1'b1;
            out_eop   <= 1'b0;
          end
        end
        S_ADDR: begin
          if (out_ready) begin
            state    <= S_CNTRL;
            out_byte <= {4'b0000, cntrl_q};
            out_sop  <= 1'b0;
          end
        end
        S_CNTRL: begin
          if (out_ready) begin
            state    <= S_DATA;
            out_byte <= data_q[0 +: DATA_W];
            out_eop  <= (LAST == 8'd0) && !CSUM_EN;
          end
        end
        S_DATA: begin
          if (out_ready) begin
            if (idx == LAST) begin
`ifdef PKT_SERIALIZER_CSUM_EN
              state    <= S_CSUM;
              out_byte <= csum_sum;
              out_eop  <= 1'b1;
`else
              state     <= S_IDLE;
              out_valid <= 1'b0;
              out_byte  <= '0;
              out_eop   <= 1'b0;
`endif
            end else begin
              idx      <= idx_nxt;
              out_byte <= data_q[int'(idx_nxt)*DATA_W +: DATA_W];
              out_eop  <= (idx_nxt == LAST) && !CSUM_EN;
            end
          end
        end
`ifdef PKT_SERIALIZER_CSUM_EN
        S_CSUM: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_eop   <= 1'b0;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_serializer.sv
`default_nettype none
// tb_pkt_serializer -- directed self-checking bench for pkt_serializer.
module tb_pkt_serializer;

  localparam int NW = 16;
`ifdef PKT_SERIALIZER_CSUM_EN
  localparam int PLEN = NW + 3;
  localparam bit CS   = 1'b1;
`else
  localparam int PLEN = NW + 2;
  localparam bit CS   = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_addr = 8'h00;
  logic [NW*8-1:0] in_data = '0;
  logic [3:0]    in_cntrl = 4'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_byte;
  logic          out_sop;
  logic          out_eop;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] cap_byte [64];
  bit         cap_sop  [64];
  bit         cap_eop  [64];
  logic [7:0] exp_b    [64];
  int         ncap;
  int         stab_err;
  bit         tmo;

  pkt_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_cntrl  (in_cntrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [NW*8-1:0] ramp_data();
    logic [NW*8-1:0] d;
    for (int i = 0; i < NW; i++) d[i*8 +: 8] = 8'(i);
    return d;
  endfunction

  // Expected stream for the basic record: 2A, 01, 00..0F, then A3 with checksum.
  task automatic fill_basic();
    exp_b[0] = 8'h2A;
    exp_b[1] = 8'h01;
    for (int i = 0; i < NW; i++) exp_b[2+i] = 8'(i);
    exp_b[NW+2] = 8'hA3;
  endtask

  // Presents one record for one cycle; called at a negedge with the DUT idle.
  task automatic send(input logic [7:0] a, input logic [NW*8-1:0] d, input logic [3:0] c);
    in_addr  = a;
    in_data  = d;
    in_cntrl = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Captures beats until the eop transfer; optional random out_ready and a busy-time in_valid pulse.
  task automatic collect(input bit bp, input int pulse_at);
    bit         pend, pulsed;
    logic [7:0] pb;
    bit         ps, pe;
    int         cyc;
    ncap = 0; stab_err = 0; tmo = 1'b0; pend = 1'b0; pulsed = 1'b0; cyc = 0;
    forever begin
      if (pulsed) in_valid = 1'b0;
      out_ready = bp ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (pend && (out_valid !== 1'b1 || out_byte !== pb || out_sop !== ps || out_eop !== pe))
        stab_err++;
      pend = out_valid && !out_ready;
      pb = out_byte; ps = out_sop; pe = out_eop;
      if (!pulsed && pulse_at >= 0 && ncap == pulse_at) begin
        in_valid = 1'b1; in_addr = 8'h55; in_cntrl = 4'hA; pulsed = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (ncap < 64) begin
          cap_byte[ncap] = out_byte; cap_sop[ncap] = out_sop; cap_eop[ncap] = out_eop;
        end
        ncap++;
        if (out_eop || ncap >= 60) begin
          @(negedge clk);
          break;
        end
      end
      cyc++;
      if (cyc > 400) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
    total++; if ({out_byte, out_sop, out_eop} !== 10'h000)
      begin bad++; $display("FAIL reset_outputs: got byte=%h sop=%b eop=%b exp 00/0/0", out_byte, out_sop, out_eop); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b exp 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic check_basic_stream(input string tag);
    total++; if (tmo || ncap != PLEN) begin bad++; $display("FAIL %s_len: got %0d beats (timeout=%b) exp %0d", tag, ncap, tmo, PLEN); end
    for (int i = 0; i < PLEN && i < ncap; i++) begin
      total++;
      if (cap_byte[i] !== exp_b[i] || cap_sop[i] !== (i == 0) || cap_eop[i] !== (i == PLEN-1)) begin
        bad++;
        $display("FAIL %s_beat[%0d]: got byte=%h sop=%b eop=%b exp byte=%h sop=%b eop=%b",
                 tag, i, cap_byte[i], cap_sop[i], cap_eop[i], exp_b[i], (i == 0), (i == PLEN-1));
      end
    end
  endtask

  task automatic test_basic();
    fill_basic();
    send(8'h2A, ramp_data(), 4'b0001);
    collect(1'b0, -1);
    check_basic_stream("basic");
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL basic_idle_after: got busy=%b valid=%b exp 0/0", busy, out_valid); end
  endtask

  task automatic test_csum_wrap();
    logic [7:0] exp_last;
    exp_last = CS ? 8'hFE : 8'hFF;
    send(8'hFF, {NW{8'hFF}}, 4'hF);
    collect(1'b0, -1);
    total++; if (tmo || ncap != PLEN) begin bad++; $display("FAIL wrap_len: got %0d exp %0d", ncap, PLEN); end
    total++; if (cap_byte[0] !== 8'hFF || cap_byte[1] !== 8'h0F)
      begin bad++; $display("FAIL wrap_head: got %h %h exp ff 0f", cap_byte[0], cap_byte[1]); end
    if (ncap >= 1 && ncap <= 64) begin
      total++; if (cap_byte[ncap-1] !== exp_last || cap_eop[ncap-1] !== 1'b1)
        begin bad++; $display("FAIL wrap_last: got %h eop=%b exp %h eop=1", cap_byte[ncap-1], cap_eop[ncap-1], exp_last); end
    end
  endtask

  task automatic test_backpressure();
    fill_basic();
    send(8'h2A, ramp_data(), 4'b0001);
    collect(1'b1, -1);
    check_basic_stream("bp");
    total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stable: got %0d changes while stalled exp 0", stab_err); end
  endtask

  task automatic test_busy_ignore();
    fill_basic();
    send(8'h2A, ramp_data(), 4'b0001);
    collect(1'b0, 5);
    check_basic_stream("ignore");
    repeat (4) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || busy !== 1'b0)
        begin bad++; $display("FAIL ignore_no_pkt: got valid=%b busy=%b exp 0/0", out_valid, busy); end
    end
  endtask

  task automatic test_back_to_back();
    logic [NW*8-1:0] db;
    int   cyc, eop_cyc, sop2_cyc;
    bit   eop_ir;
    logic [7:0] first_b;
    bit   first_sop;
    db = ~ramp_data();
    eop_cyc = -1; sop2_cyc = -1; eop_ir = 1'b1; first_b = 8'h00; first_sop = 1'b0;
    out_ready = 1'b1;
    in_addr = 8'h11; in_data = ramp_data(); in_cntrl = 4'h3; in_valid = 1'b1;
    for (cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        first_b = out_byte; first_sop = out_sop;
        in_addr = 8'h22; in_data = db; in_cntrl = 4'h4;
      end
      if (out_valid && out_eop && eop_cyc < 0) begin
        eop_cyc = cyc; eop_ir = in_ready;
      end else if (out_valid && out_sop && eop_cyc >= 0) begin
        sop2_cyc = cyc;
        in_valid = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
    total++; if (first_b !== 8'h11 || first_sop !== 1'b1)
      begin bad++; $display("FAIL b2b_first: got %h sop=%b exp 11 sop=1", first_b, first_sop); end
    total++; if (eop_cyc < 0 || sop2_cyc - eop_cyc != 2)
      begin bad++; $display("FAIL b2b_gap: got eop@%0d sop@%0d exp gap 2", eop_cyc, sop2_cyc); end
    total++; if (eop_ir !== 1'b0) begin bad++; $display("FAIL b2b_ready_on_eop: got %b exp 0", eop_ir); end
    if (sop2_cyc > 0) begin
      collect(1'b0, -1);
      total++; if (cap_byte[0] !== 8'h22 || cap_byte[1] !== 8'h04 || cap_byte[2] !== 8'hFF || ncap != PLEN)
        begin bad++; $display("FAIL b2b_second: got %h %h %h len=%0d exp 22 04 ff len=%0d",
                              cap_byte[0], cap_byte[1], cap_byte[2], ncap, PLEN); end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bit saw_eop;
    n = 0; saw_eop = 1'b0;
    send(8'h2A, ramp_data(), 4'b0001);
    out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (out_valid && out_eop) saw_eop = 1'b1;
      if (out_valid && out_ready) n++;
      if (n == 7) break;
      @(negedge clk);
    end
    total++; if (n != 7) begin bad++; $display("FAIL midrst_progress: got %0d beats exp 7", n); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_eop !== 1'b0 || saw_eop)
      begin bad++; $display("FAIL midrst_outputs: got valid=%b busy=%b eop=%b early_eop=%b exp 0/0/0/0",
                            out_valid, busy, out_eop, saw_eop); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h3C, ramp_data(), 4'h2);
    collect(1'b0, -1);
    total++; if (cap_byte[0] !== 8'h3C || cap_sop[0] !== 1'b1 || ncap != PLEN)
      begin bad++; $display("FAIL midrst_restart: got %h sop=%b len=%0d exp 3c sop=1 len=%0d",
                            cap_byte[0], cap_sop[0], ncap, PLEN); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_csum_wrap();
    test_backpressure();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion exp finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
